// File: rtl/serial_flow_cmp_add.sv
`default_nettype none
// serial_flow_cmp_add - CHANNELS LSB-first serial add/compare lanes framed by sof, per-frame mode. Rev 1.0
module serial_flow_cmp_add #(
   parameter int CHANNELS  = 4,
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = $clog2(FRAME_LEN)
) (
   input  logic                clk_pad,
   input  logic                rst_n_pad,
   input  logic                sof_pad,
   input  logic                in_valid_pad,
   input  logic                mode_pad,
   input  logic [CHANNELS-1:0] a_pad,
   input  logic [CHANNELS-1:0] b_pad,
   output logic [CHANNELS-1:0] sum_pad,
   output logic                sum_valid_pad,
   output logic [CHANNELS-1:0] ovf_pad,
   output logic [CHANNELS-1:0] eq_pad,
   output logic [CHANNELS-1:0] gt_pad,
   output logic                frame_done_pad,
   output logic                busy_pad
);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
   localparam logic             MODE_CMP = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [1:0]          rst_sync;
   logic                rst_n;
   logic                start;
   logic                step;
   logic                last;
   logic                frame_mode;
   logic                mode_q;
   logic [CNT_W-1:0]    cnt;
   logic [CHANNELS-1:0] carry;
   logic [CHANNELS-1:0] eqf;
   logic [CHANNELS-1:0] gtf;
   logic [CHANNELS-1:0] carry_nxt;
   logic [CHANNELS-1:0] eqf_nxt;
   logic [CHANNELS-1:0] gtf_nxt;
   logic [CHANNELS-1:0] sum_bit;

   // Reset asserts immediately from the pad, releases two clocks later.
   always_ff @(posedge clk_pad or negedge rst_n_pad) begin
      if (!rst_n_pad) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n = rst_sync[1];

   // An accepted sof always restarts, aborting any frame in flight.
   assign start      = in_valid_pad & sof_pad;
   assign step       = start | (in_valid_pad & (state == RUN));
   assign last       = in_valid_pad & ~sof_pad & (state == RUN) & (cnt == LAST_CNT);
   assign frame_mode = start ? mode_pad : mode_q;
   assign busy_pad   = (state == RUN);

   always_ff @(posedge clk_pad or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic c_in;
      logic e_in;
      logic g_in;
      logic diff;

      assign c_in         = start ? 1'b0 : carry[i];
      assign e_in         = start ? 1'b1 : eqf[i];
      assign g_in         = start ? 1'b0 : gtf[i];
      assign diff         = a_pad[i] ^ b_pad[i];
      assign sum_bit[i]   = diff ^ c_in;
      assign carry_nxt[i] = (a_pad[i] & b_pad[i]) | (a_pad[i] & c_in) | (b_pad[i] & c_in);
      assign eqf_nxt[i]   = e_in & ~diff;
      // Later bits are more significant, so any differing bit overrides history.
      assign gtf_nxt[i]   = diff ? a_pad[i] : g_in;
   end

   always_ff @(posedge clk_pad or negedge rst_n) begin
      if (!rst_n) begin
         cnt            <= '0;
         mode_q         <= 1'b0;
         carry          <= '0;
         eqf            <= '0;
         gtf            <= '0;
         sum_pad        <= '0;
         sum_valid_pad  <= 1'b0;
         ovf_pad        <= '0;
         eq_pad         <= '0;
         gt_pad         <= '0;
         frame_done_pad <= 1'b0;
      end else begin
         if (start) begin
            mode_q <= mode_pad;
            cnt    <= ONE_CNT;
         end else if (step && !last) begin
            cnt <= cnt + ONE_CNT;
         end

         if (step) begin
            carry   <= carry_nxt;
            eqf     <= eqf_nxt;
            gtf     <= gtf_nxt;
            sum_pad <= (frame_mode == MODE_CMP) ? '0 : sum_bit;
         end

         sum_valid_pad  <= step & (frame_mode != MODE_CMP);
         frame_done_pad <= last;

         if (last) begin
            ovf_pad <= (mode_q == MODE_CMP) ? '0 : carry_nxt;
            eq_pad  <= eqf_nxt;
            gt_pad  <= gtf_nxt;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_flow_cmp_add.sv
`default_nettype none
// tb_serial_flow_cmp_add - directed frame vectors plus abort, back-to-back and reset sequences. Rev 1.0
`timescale 1ns/1ps
module tb_serial_flow_cmp_add;
   localparam int CH = 4;
   localparam int FL = 8;

   logic          clk_pad = 1'b0;
   logic          rst_n_pad;
   logic          sof_pad;
   logic          in_valid_pad;
   logic          mode_pad;
   logic [CH-1:0] a_pad;
   logic [CH-1:0] b_pad;
   logic [CH-1:0] sum_pad;
   logic          sum_valid_pad;
   logic [CH-1:0] ovf_pad;
   logic [CH-1:0] eq_pad;
   logic [CH-1:0] gt_pad;
   logic          frame_done_pad;
   logic          busy_pad;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [CH*FL-1:0] a;
      logic [CH*FL-1:0] b;
      logic [CH*FL-1:0] sum;
      logic             mode;
      logic [CH-1:0]    ovf;
      logic [CH-1:0]    eq;
      logic [CH-1:0]    gt;
      int               bub_at;
      int               bub_len;
   } vec_t;

   vec_t vecs[5];

   serial_flow_cmp_add #(
      .CHANNELS  (CH),
      .FRAME_LEN (FL)
   ) dut (
      .clk_pad        (clk_pad),
      .rst_n_pad      (rst_n_pad),
      .sof_pad        (sof_pad),
      .in_valid_pad   (in_valid_pad),
      .mode_pad       (mode_pad),
      .a_pad          (a_pad),
      .b_pad          (b_pad),
      .sum_pad        (sum_pad),
      .sum_valid_pad  (sum_valid_pad),
      .ovf_pad        (ovf_pad),
      .eq_pad         (eq_pad),
      .gt_pad         (gt_pad),
      .frame_done_pad (frame_done_pad),
      .busy_pad       (busy_pad)
   );

   always #5 clk_pad = ~clk_pad;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic beat(input logic v, input logic s, input logic m,
                       input logic [CH-1:0] a, input logic [CH-1:0] b);
      @(negedge clk_pad);
      in_valid_pad = v;
      sof_pad      = s;
      mode_pad     = m;
      a_pad        = a;
      b_pad        = b;
      @(posedge clk_pad);
      #1;
   endtask

   task automatic run_frame(input int idx, input int nbits);
      vec_t          v;
      logic [CH-1:0] ab;
      logic [CH-1:0] bb;
      logic [CH-1:0] sb;
      logic [CH:0]   exp_s;
      v = vecs[idx];
      for (int k = 0; k < nbits; k++) begin
         if (k == v.bub_at) begin
            for (int j = 0; j < v.bub_len; j++) begin
               beat(1'b0, 1'b0, ~v.mode, CH'($urandom), CH'($urandom));
               check("bubble_sum_valid", 32'(sum_valid_pad), 32'd0);
               check("bubble_busy_done", 32'({frame_done_pad, busy_pad}), 32'b01);
            end
         end
         for (int c = 0; c < CH; c++) begin
            ab[c] = v.a[c*FL+k];
            bb[c] = v.b[c*FL+k];
            sb[c] = v.sum[c*FL+k];
         end
         beat(1'b1, (k == 0), (k == 0) ? v.mode : ~v.mode, ab, bb);
         exp_s = v.mode ? '0 : {1'b1, sb};
         check("sum_bit", 32'({sum_valid_pad, sum_pad}), 32'(exp_s));
         if (k == FL-1) begin
            check("done_busy_last", 32'({frame_done_pad, busy_pad}), 32'b10);
            check("ovf_eq_gt", 32'({ovf_pad, eq_pad, gt_pad}), 32'({v.ovf, v.eq, v.gt}));
         end else begin
            check("done_busy_mid", 32'({frame_done_pad, busy_pad}), 32'b01);
         end
      end
   endtask

   task automatic idle_check(input int idx);
      beat(1'b0, 1'b0, 1'b0, '0, '0);
      check("idle_done_busy_valid", 32'({frame_done_pad, busy_pad, sum_valid_pad}), 32'b000);
      check("held_ovf_eq_gt", 32'({ovf_pad, eq_pad, gt_pad}),
            32'({vecs[idx].ovf, vecs[idx].eq, vecs[idx].gt}));
   endtask

   initial begin
      // channel c occupies bits [c*FL +: FL]; literals read {ch3, ch2, ch1, ch0}
      vecs[0] = '{a: {8'h80, 8'h00, 8'hFF, 8'h5A}, b: {8'h80, 8'h00, 8'h01, 8'h33},
                  sum: {8'h00, 8'h00, 8'h00, 8'h8D}, mode: 1'b0,
                  ovf: 4'b1010, eq: 4'b1100, gt: 4'b0011, bub_at: -1, bub_len: 0};
      vecs[1] = '{a: {8'hAA, 8'h01, 8'h80, 8'hC3}, b: {8'h55, 8'h02, 8'h7F, 8'hC3},
                  sum: '0, mode: 1'b1,
                  ovf: 4'b0000, eq: 4'b0001, gt: 4'b1010, bub_at: -1, bub_len: 0};
      vecs[2] = '{a: {8'hC8, 8'h7F, 8'h12, 8'hFF}, b: {8'h37, 8'h01, 8'h34, 8'hFF},
                  sum: {8'hFF, 8'h80, 8'h46, 8'hFE}, mode: 1'b0,
                  ovf: 4'b0001, eq: 4'b0001, gt: 4'b1100, bub_at: -1, bub_len: 0};
      vecs[3] = '{a: {8'h01, 8'h10, 8'hFF, 8'h00}, b: {8'h80, 8'h20, 8'hFE, 8'h00},
                  sum: '0, mode: 1'b1,
                  ovf: 4'b0000, eq: 4'b0001, gt: 4'b0010, bub_at: -1, bub_len: 0};
      vecs[4] = vecs[0];
      vecs[4].bub_at  = 4;
      vecs[4].bub_len = 3;

      rst_n_pad    = 1'b0;
      sof_pad      = 1'b0;
      in_valid_pad = 1'b0;
      mode_pad     = 1'b0;
      a_pad        = '0;
      b_pad        = '0;

      repeat (3) @(posedge clk_pad);
      #1;
      check("reset_outputs", 32'({sum_pad, sum_valid_pad, ovf_pad, eq_pad, gt_pad, frame_done_pad, busy_pad}), 32'd0);
      @(negedge clk_pad);
      rst_n_pad = 1'b1;
      repeat (3) beat(1'b0, 1'b0, 1'b0, '0, '0);

      // accepted beat without sof in IDLE is ignored
      beat(1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
      check("idle_no_sof", 32'({busy_pad, sum_valid_pad, frame_done_pad}), 32'b000);

      for (int i = 0; i < 5; i++) begin
         run_frame(i, FL);
         idle_check(i);
      end

      // abort: sof at bit 4 restarts; no done pulse for the aborted frame
      run_frame(0, 4);
      run_frame(2, FL);
      idle_check(2);

      // back-to-back: second sof lands in the DONE cycle
      run_frame(1, FL);
      run_frame(3, FL);
      idle_check(3);

      // asynchronous reset mid-frame
      run_frame(0, 3);
      @(negedge clk_pad);
      in_valid_pad = 1'b0;
      #2;
      rst_n_pad = 1'b0;
      #1;
      check("async_reset_immediate", 32'({sum_pad, sum_valid_pad, ovf_pad, eq_pad, gt_pad, frame_done_pad, busy_pad}), 32'd0);
      @(posedge clk_pad);
      #1;
      check("async_reset_held", 32'({sum_pad, sum_valid_pad, ovf_pad, eq_pad, gt_pad, frame_done_pad, busy_pad}), 32'd0);
      @(negedge clk_pad);
      #3;
      rst_n_pad = 1'b1;
      repeat (3) beat(1'b0, 1'b0, 1'b0, '0, '0);
      run_frame(2, FL);
      idle_check(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_flow_cmp_add.md
Name: serial_flow_cmp_add

Overview:
- Parametrised, sequential successor to the single-bit serial compare/steer cell.
- Processes CHANNELS independent pairs of LSB-first serial bit streams in frames of FRAME_LEN bits.
- Per frame, runtime-selectable: mode 0 computes a bit-serial sum with carry; mode 1 computes frame-level equality and greater-than.
- Sits between pad-level serial inputs and the frame-result collection logic.

Parameters:
- CHANNELS, 4, number of independent a/b stream pairs
- FRAME_LEN, 8, bits per frame (≥2)
- CNT_W, $clog2(FRAME_LEN), bit-counter width

Ports:
- clk_pad  in  1  clock, rising edge
- rst_n_pad  in  1  asynchronous active-low reset
- sof_pad  in  1  start of frame; qualified by in_valid_pad; marks bit 0
- in_valid_pad  in  1  current a/b bits valid
- mode_pad  in  1  0 = add, 1 = compare; sampled only on accepted sof
- a_pad  in  CHANNELS  serial bit per channel, stream A
- b_pad  in  CHANNELS  serial bit per channel, stream B
- sum_pad  out  CHANNELS  registered serial sum bit (add mode); 0 in compare mode
- sum_valid_pad  out  1  sum_pad valid
- ovf_pad  out  CHANNELS  final carry-out; valid with frame_done_pad
- eq_pad  out  CHANNELS  frame A==B; valid with frame_done_pad
- gt_pad  out  CHANNELS  frame A>B unsigned; valid with frame_done_pad
- frame_done_pad  out  1  one-cycle pulse when a frame completes
- busy_pad  out  1  high while in RUN

Behaviour:
- Reset (async assert, sync release) clears all outputs, state, counters, carry, eq and gt flags.
  - Reset values: state=IDLE, sum_pad=0, sum_valid_pad=0, ovf_pad=0, eq_pad=0, gt_pad=0, frame_done_pad=0, busy_pad=0.
- A beat is accepted when in_valid_pad=1. When in_valid_pad=0, all state holds and sum_valid_pad=0 on the next cycle.
- States:
  - IDLE: an accepted beat with sof_pad=1 latches mode, processes bit 0, sets cnt=1, and goes to RUN. Accepted beats without sof are ignored.
  - RUN: each accepted beat processes one bit and increments cnt. The beat with cnt==FRAME_LEN-1 is the last bit; it goes to DONE.
  - DONE: lasts one cycle. frame_done_pad=1 with results. Then go to IDLE. An accepted sof beat in this cycle starts a new frame directly (go to RUN, cnt=1).
- Per-bit processing, channel i, with running state carry[i], eqf[i], gtf[i]. These are initialised on the sof beat as carry=0, eqf=1, gtf=0 before bit 0 is applied.
  - Add: s = a^b^carry; carry <= (a&b)|(a&carry)|(b&carry). sum_pad[i] <= s and sum_valid_pad <= 1 on the following cycle (latency 1).
  - Compare: eqf <= eqf & ~(a^b). gtf <= (a&~b) ? 1 : (~a&b) ? 0 : gtf, so the most-significant differing bit wins.
  - Both flags are maintained in both modes. sum_pad is forced to 0 and sum_valid_pad stays 0 in compare mode.
- On frame_done_pad:
  - ovf_pad = final carry in add mode, 0 in compare mode.
  - eq_pad and gt_pad = final flags in both modes.
  - eq_pad, gt_pad and ovf_pad hold their values until the next frame_done_pad or reset.
- Accepted sof while in RUN: the current frame is aborted with no frame_done_pad. State reinitialises and that beat is treated as bit 0 of the new frame.
- mode_pad changes mid-frame are ignored.
- Counter never wraps past FRAME_LEN-1. busy_pad = (state==RUN).

Test Plan:
- FRAME_LEN=8, CHANNELS=4, add mode, ch0 A=0x5A, B=0x33, contiguous valid:
  - sum_pad ch0 serialises 0x8D LSB-first, one cycle after each input bit.
  - ovf_pad[0]=0, frame_done_pad one cycle after the last-bit cycle.
  - Also ch1 A=0xFF, B=0x01 -> sum 0x00, ovf_pad[1]=1.
- Compare mode, ch0 A=B=0xC3, ch1 A=0x80 B=0x7F, ch2 A=0x01 B=0x02:
  - eq_pad=…0001b; gt_pad[1]=1, gt_pad[2]=0, gt_pad[0]=0; sum_valid_pad never asserts.
- Add frame with in_valid_pad low for 3 cycles mid-frame:
  - Results identical to the contiguous case; sum_valid_pad low during bubbles; busy_pad stays high.
- sof_pad re-asserted at bit 4 of a frame:
  - No frame_done_pad for the aborted frame; the new frame completes after 8 further valid beats with correct results.
- Back-to-back frames with sof in the DONE cycle:
  - Two frame_done_pad pulses 8 valid beats apart; no lost bit.
- rst_n_pad pulsed low mid-frame (asynchronously, between edges):
  - All outputs 0 immediately; next frame after release processed correctly from IDLE.
